// File: rtl/access_ctrl.sv
// ============================================================================
// Module   : access_ctrl
// Purpose  : Door access controller. Grants a timed door opening after a
//            successful entry attempt. Counts consecutive failed attempts
//            and enters a timed lockout after MAX_FAIL failures.
// Options  : ACCESS_ALARM_EN adds a sticky alarm output and an alarm_ack input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module access_ctrl #(
  parameter int MAX_FAIL    = 3,     // 1..15
  parameter int OPEN_CYCLES = 50,    // 1..65535
  parameter int LOCK_CYCLES = 1000   // 1..65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pass_ok,
  input  logic       attempt_done,
`ifdef ACCESS_ALARM_EN
  input  logic       alarm_ack,
  output logic       alarm,
`endif
  output logic       door_open,
  output logic       locked,
  output logic [3:0] fail_cnt,
  output logic       key_en
);

  localparam logic [15:0] OPEN_LOAD = 16'(OPEN_CYCLES - 1);
  localparam logic [15:0] LOCK_LOAD = 16'(LOCK_CYCLES - 1);
  localparam logic [4:0]  FAIL_MAX  = 5'(MAX_FAIL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  fail_cnt_q, fail_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        match_seen_q, match_seen_d;

  // Failure count after this attempt, one bit wider so the compare never truncates.
  logic [4:0]  fail_next;
  assign fail_next = {1'b0, fail_cnt_q} + 5'd1;

  // State, failure counter, timer and match latch registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fail_cnt_q   <= 4'd0;
      timer_q      <= 16'd0;
      match_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      match_seen_q <= match_seen_d;
    end
  end

  // Next-state logic: attempt evaluation in IDLE, timed dwell in OPEN/LOCKED.
  always_comb begin
    state_d      = state_q;
    fail_cnt_d   = fail_cnt_q;
    timer_d      = timer_q;
    match_seen_d = match_seen_q;
    case (state_q)
      IDLE: begin
        if (attempt_done) begin
          // Every attempt closes the match window, successful or not.
          match_seen_d = 1'b0;
          if (match_seen_q || pass_ok) begin
            state_d    = OPEN;
            fail_cnt_d = 4'd0;
            timer_d    = OPEN_LOAD;
          end else if (fail_next == FAIL_MAX) begin
            state_d    = LOCKED;
            fail_cnt_d = FAIL_MAX[3:0];
            timer_d    = LOCK_LOAD;
          end else begin
            fail_cnt_d = fail_next[3:0];
          end
        end else if (pass_ok) begin
          match_seen_d = 1'b1;
        end
      end
      OPEN: begin
        // Inputs are ignored here; the timer holds at 0 rather than wrapping.
        match_seen_d = 1'b0;
        if (timer_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      LOCKED: begin
        match_seen_d = 1'b0;
        if (timer_q == 16'd0) begin
          state_d    = IDLE;
          fail_cnt_d = 4'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d      = IDLE;
        match_seen_d = 1'b0;
      end
    endcase
  end

  // Outputs decode from registered state only, so reset acts on them immediately.
  assign door_open = (state_q == OPEN);
  assign locked    = (state_q == LOCKED);
  assign key_en    = (state_q == IDLE);
  assign fail_cnt  = fail_cnt_q;

`ifdef ACCESS_ALARM_EN
  logic alarm_q;
  logic lock_entry;

  // Registered alarm rises together with locked because both load on the same edge.
  assign lock_entry = (state_q == IDLE) && (state_d == LOCKED);

  // Sticky alarm: set on lockout entry (wins over ack), cleared by acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alarm_q <= 1'b0;
    end else if (lock_entry) begin
      alarm_q <= 1'b1;
    end else if (alarm_ack) begin
      alarm_q <= 1'b0;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule

`default_nettype wire
